// File: rtl/srv_line_fill.sv
// Instruction-cache line-fill responder: reads one ROM word per beat (with optional
// wait states), assembles a full cache line and returns it with a one-cycle response pulse.
module srv_line_fill #(
    parameter int WORDS_PER_LINE = 4,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  ext_addr_i,
    input  logic                         ext_req_i,
    output logic                         ext_rsp_o,
    output logic [32*WORDS_PER_LINE-1:0] ext_data_o,
    output logic [31:0]                  rom_addr_o,
    input  logic [31:0]                  rom_data_i,
    output logic                         busy_o
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [3:0]       WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t           state;
    logic [31:0]      base;
    logic [OFF_W-1:0] wcnt;
    logic [3:0]       wt;

    // rom_addr_o is kept as a register so every output comes straight from a flop;
    // the word offset only ever replaces the zeroed low bits, so it cannot carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            wcnt       <= '0;
            wt         <= '0;
            ext_rsp_o  <= 1'b0;
            busy_o     <= 1'b0;
            ext_data_o <= '0;
            rom_addr_o <= '0;
        end else begin
            ext_rsp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_req_i) begin
                        base       <= {ext_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                        rom_addr_o <= {ext_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                        wcnt       <= '0;
                        wt         <= '0;
                        busy_o     <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (wt != WAIT_LAST) begin
                        wt <= 4'(wt + 1'b1);
                    end else begin
                        wt <= '0;
                        ext_data_o[{wcnt, 5'b0} +: 32] <= rom_data_i;
                        if (wcnt == LAST_WORD) begin
                            rom_addr_o <= base;
                            ext_rsp_o  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            wcnt       <= OFF_W'(wcnt + 1'b1);
                            rom_addr_o <= {base[31:OFF_W], OFF_W'(wcnt + 1'b1)};
                        end
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srv_line_fill.sv
// Directed bench for srv_line_fill: default instance plus a WAIT_CYCLES=2 instance,
// both fed by a ROM model returning 0x1000_0000 + address.
module tb_srv_line_fill;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr_a = '0, addr_b = '0;
    logic         req_a = 1'b0, req_b = 1'b0;
    logic         rsp_a, rsp_b, busy_a, busy_b;
    logic [127:0] data_a, data_b;
    logic [31:0]  rom_addr_a, rom_addr_b;
    logic [31:0]  rom_data_a, rom_data_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data_a = 32'h1000_0000 + rom_addr_a;
    assign rom_data_b = 32'h1000_0000 + rom_addr_b;

    srv_line_fill dut_a (
        .clk(clk), .rst(rst), .ext_addr_i(addr_a), .ext_req_i(req_a), .ext_rsp_o(rsp_a),
        .ext_data_o(data_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a), .busy_o(busy_a)
    );

    srv_line_fill #(.WORDS_PER_LINE(4), .WAIT_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .ext_addr_i(addr_b), .ext_req_i(req_b), .ext_rsp_o(rsp_b),
        .ext_data_o(data_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b), .busy_o(busy_b)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_cnt;
        int rsp_cyc [2];
        logic saw_40;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_rsp", rsp_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_data", data_a, 0);
        check_val("rst_addr", rom_addr_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: defaults, addr 6 -> line 4..7, rsp in cycle 5
        req_a = 1'b1; addr_a = 32'h6;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                check_val($sformatf("t1_addr_c%0d", k), rom_addr_a, 32'(3 + k));
                check_val($sformatf("t1_rsp_c%0d", k), rsp_a, 0);
                check_val($sformatf("t1_busy_c%0d", k), busy_a, 1);
            end else if (k == 5) begin
                check_val("t1_rsp_c5", rsp_a, 1);
                check_val("t1_data", data_a, 128'h10000007_10000006_10000005_10000004);
                check_val("t1_addr_resp", rom_addr_a, 32'h4);
                req_a = 1'b0;
            end else begin
                check_val($sformatf("t1_rsp_c%0d", k), rsp_a, 0);
                check_val($sformatf("t1_busy_c%0d", k), busy_a, 0);
            end
        end

        // Test 2: WAIT_CYCLES=2, addr 9 -> each address held 3 cycles, rsp in cycle 13
        req_b = 1'b1; addr_b = 32'h9;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                check_val($sformatf("t2_addr_c%0d", k), rom_addr_b, 32'(8 + (k - 1) / 3));
                check_val($sformatf("t2_rsp_c%0d", k), rsp_b, 0);
            end else if (k == 13) begin
                check_val("t2_rsp_c13", rsp_b, 1);
                check_val("t2_data", data_b, 128'h1000000B_1000000A_10000009_10000008);
                req_b = 1'b0;
            end else begin
                check_val("t2_rsp_c14", rsp_b, 0);
            end
        end

        // Test 3: request dropped and address changed mid-fill
        req_a = 1'b1; addr_a = 32'h11;
        rsp_cnt = 0; saw_40 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (rom_addr_a == 32'h40) saw_40 = 1'b1;
            if (rsp_a) begin
                rsp_cnt++;
                check_val("t3_rsp_cycle", k, 5);
                check_val("t3_data", data_a, 128'h10000013_10000012_10000011_10000010);
            end
            if (k == 2) begin
                req_a = 1'b0; addr_a = 32'h40;
            end
        end
        check_val("t3_rsp_count", rsp_cnt, 1);
        check_val("t3_no_addr40", saw_40, 0);

        // Test 4: request held across RESP -> back-to-back fills 6 cycles apart
        req_a = 1'b1; addr_a = 32'h0;
        rsp_cnt = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (rsp_a) begin
                if (rsp_cnt == 0)
                    check_val("t4_data1", data_a, 128'h10000003_10000002_10000001_10000000);
                else
                    check_val("t4_data2", data_a, 128'h10000007_10000006_10000005_10000004);
                if (rsp_cnt < 2) rsp_cyc[rsp_cnt] = k;
                rsp_cnt++;
                if (rsp_cnt == 1) addr_a = 32'h4;
                else req_a = 1'b0;
            end
        end
        check_val("t4_rsp_count", rsp_cnt, 2);
        check_val("t4_first_cycle", rsp_cyc[0], 5);
        check_val("t4_spacing", rsp_cyc[1] - rsp_cyc[0], 6);
        req_a = 1'b0;

        // Test 5: async reset in the 3rd FETCH cycle aborts the fill
        req_a = 1'b1; addr_a = 32'h20;
        repeat (3) @(negedge clk);
        check_val("t5_busy_before", busy_a, 1);
        #1 rst = 1'b1; req_a = 1'b0;
        #1;
        check_val("t5_rst_busy", busy_a, 0);
        check_val("t5_rst_rsp", rsp_a, 0);
        check_val("t5_rst_data", data_a, 0);
        check_val("t5_rst_addr", rom_addr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_a) rsp_cnt++;
        end
        check_val("t5_no_rsp", rsp_cnt, 0);
        req_a = 1'b1; addr_a = 32'h24;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check_val("t5_after_rsp", rsp_a, 1);
                check_val("t5_after_data", data_a, 128'h10000027_10000026_10000025_10000024);
                req_a = 1'b0;
            end
        end

        // Test 6: top-of-memory line, no wrap
        req_a = 1'b1; addr_a = 32'hFFFF_FFFE;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                check_val($sformatf("t6_addr_c%0d", k), rom_addr_a, 32'hFFFF_FFFB + 32'(k));
            end else if (k == 5) begin
                check_val("t6_rsp", rsp_a, 1);
                check_val("t6_data", data_a, 128'h0FFFFFFF_0FFFFFFE_0FFFFFFD_0FFFFFFC);
                check_val("t6_addr_resp", rom_addr_a, 32'hFFFF_FFFC);
                req_a = 1'b0;
            end else begin
                check_val("t6_rsp_c6", rsp_a, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srv_line_fill.md
# srv_line_fill

Line-fill responder on the instruction-cache refill interface: accepts a line request from the I-cache (`ext_req_i`/`ext_addr_i`), reads the line one word per beat from the 32-bit asynchronous program ROM, assembles the words into a full cache line and returns it with a one-cycle `ext_rsp_o` pulse. It sits between the I-cache refill port and the ROM in the top level. A programmable wait-state count emulates slower backing memory for cache-miss testing.

## Interface
- `WORDS_PER_LINE`, 4, words per cache line; power of two, 2..8; line width `LW = 32*WORDS_PER_LINE`.
- `WAIT_CYCLES`, 0, extra cycles each ROM address is held before its word is captured; 0..15.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ext_addr_i`  in  32  word address of the requested instruction; any word inside the line.
- `ext_req_i`  in  1  line request; level, held by the requester until `ext_rsp_o`.
- `ext_rsp_o`  out  1  one-cycle pulse: `ext_data_o` holds the complete line.
- `ext_data_o`  out  LW  assembled line; word i in bits `[32*i+31:32*i]`.
- `rom_addr_o`  out  32  ROM word address.
- `rom_data_i`  in  32  ROM word, combinational from `rom_addr_o`.
- `busy_o`  out  1  high while a fill is in progress (FETCH or RESP).

## Operation
- States: IDLE, FETCH, RESP.
- IDLE: if `ext_req_i`=1 at an edge, latch `base = {ext_addr_i[31:log2(WORDS_PER_LINE)], 0}`, clear word counter `wcnt` and wait counter `wt`, go FETCH. Otherwise stay.
- FETCH: `rom_addr_o = base + wcnt` (OR into the zeroed low bits; never carries into upper bits, so base 0xFFFFFFFC is legal).
  - If `wt < WAIT_CYCLES`: `wt` increments, no capture.
  - Else: capture `rom_data_i` into line word `wcnt`, clear `wt`; if `wcnt == WORDS_PER_LINE-1` go RESP, else `wcnt` increments.
- RESP: `ext_rsp_o`=1 for exactly this cycle; next state IDLE.
- `ext_data_o` is the line register itself; only guaranteed complete while `ext_rsp_o`=1; words are overwritten in order during the next fill.
- In IDLE and RESP `rom_addr_o` holds the last latched `base`.
- `ext_addr_i` changes and `ext_req_i` deassertion during FETCH are ignored; the fill always completes and `ext_rsp_o` always pulses.
- `ext_req_i` still high in IDLE after a RESP is a new request (back-to-back fills allowed); a single-transfer requester drops `ext_req_i` during the RESP cycle.
- `busy_o` = state != IDLE.

## Timing
- Reset (async, any state): state IDLE, `ext_rsp_o`=0, `busy_o`=0, `ext_data_o`=0, `rom_addr_o`=0, `wcnt`=`wt`=0. Reset mid-fill aborts it; no response is produced.
- Latency: request sampled at edge E0 -> `ext_rsp_o` high in cycle `WORDS_PER_LINE*(WAIT_CYCLES+1)+1` after E0 (5 for defaults).
- Word i is captured at the edge ending its `(WAIT_CYCLES+1)`-th FETCH cycle.
- Back-to-back: minimum spacing between two `ext_rsp_o` pulses is `WORDS_PER_LINE*(WAIT_CYCLES+1)+2` cycles.
- No combinational path from any input to any output; `rom_data_i` is sampled only at edges.

## Test plan
- Defaults, ROM word n = 0x1000_0000+n; req with `ext_addr_i`=0x0000_0006 -> `rom_addr_o` 4,5,6,7 in successive cycles; `ext_rsp_o` in cycle 5; `ext_data_o`=0x10000007_10000006_10000005_10000004; single pulse.
- `WAIT_CYCLES`=2, addr 0x0000_0009 -> each address held 3 cycles; rsp in cycle 13; data = words 8..11.
- `ext_req_i` dropped and `ext_addr_i` changed to 0x40 after 2 FETCH cycles -> fill of original line completes, rsp in cycle 5, `rom_addr_o` never 0x40.
- `ext_req_i` held high across RESP with addr 0 then 4 -> two fills, rsp pulses 6 cycles apart, second line = words 4..7.
- `rst` asserted asynchronously in 3rd FETCH cycle -> immediate IDLE, all outputs 0, no rsp; new request after release completes normally.
- Addr 0xFFFF_FFFE -> `rom_addr_o` 0xFFFFFFFC..0xFFFFFFFF, no wrap to 0, rsp in cycle 5.
